// File: rtl/pipe_mux_skid.sv
// -----------------------------------------------------------------------------
// pipe_mux_skid
//
// NUM_IN-way, WIDTH-bit selector feeding a registered valid/ready output stage
// with a one-entry skid buffer. Each accepted transfer selects one input. The
// result and an out-of-range flag are registered and held until the consumer
// takes them. This lets the selector sit on back-pressured paths such as
// operand forwarding into a stalled execute stage.
//
// Parameters
//   WIDTH      data width of each input and of the output
//   NUM_IN     number of inputs (>= 2)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    flattened inputs, input i at bits [i*WIDTH +: WIDTH]
//   in_sel     select index
//   in_valid   producer offers a transfer
//   in_ready   block can accept (register output)
//   out_data   selected data (register output)
//   out_err    captured select was >= NUM_IN (register output)
//   out_valid  out_data/out_err hold a transfer (register output)
//   out_ready  consumer accepts
//   flush      synchronous discard of all held transfers
//   stat_cnt   saturating count of output fires (only with the macro below)
//
// Build option
//   PIPE_MUX_SKID_STAT_EN  when defined, adds the 16-bit stat_cnt output. The
//                          counter is cleared by reset and by flush.
// -----------------------------------------------------------------------------
module pipe_mux_skid #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [$clog2(NUM_IN)-1:0] in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_err,
   output logic                    out_valid,
   input  logic                    out_ready,
   input  logic                    flush
`ifdef PIPE_MUX_SKID_STAT_EN
   ,
   output logic [15:0]             stat_cnt
`endif
);

   localparam int SEL_W = $clog2(NUM_IN);

   // EMPTY: nothing held. BUSY: main register holds a transfer.
   // FULL: main and skid registers both hold a transfer.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] skid_data;
   logic             skid_err;

   logic [WIDTH-1:0] sel_data;
   logic             sel_err;
   logic             in_fire;
   logic             out_fire;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // The selector defaults to the last input and flags an error. Any
   // in-range index then overrides that default, which gives the legacy
   // default-to-last behaviour for indices >= NUM_IN.
   // NOTE: assign every always_comb output before any branch or loop. A path
   // that leaves a signal unassigned infers a latch.
   always_comb begin
      sel_data = in_data[(NUM_IN-1)*WIDTH +: WIDTH];
      sel_err  = 1'b1;
      for (int i = 0; i < NUM_IN; i++) begin
         if (in_sel == SEL_W'(i)) begin
            sel_data = in_data[i*WIDTH +: WIDTH];
            sel_err  = 1'b0;
         end
      end
   end

   // Control, output and skid registers share one process. Each transition
   // updates in_ready together with the state, so in_ready always equals
   // (state != FULL) and no output depends combinationally on an input.
   // NOTE: clocked state uses non-blocking assignments only. Every register
   // then samples its pre-edge value, whatever the order of the statements.
   // NOTE: the skid register is reset along with the main register. An
   // idle block therefore holds no stale data after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
         skid_data <= '0;
         skid_err  <= 1'b0;
         in_ready  <= 1'b1;
      end else if (flush) begin
         // Flush wins over any fire in the same cycle. A transfer offered in
         // this cycle is dropped. The data registers keep stale values that
         // no consumer may look at while out_valid is low.
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  out_data  <= sel_data;
                  out_err   <= sel_err;
                  out_valid <= 1'b1;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (in_fire && out_ready) begin
                  // Pass-through: the old transfer leaves and the new one
                  // replaces it in the same cycle.
                  out_data <= sel_data;
                  out_err  <= sel_err;
               end else if (in_fire) begin
                  // Consumer stalled: park the new transfer in the skid slot.
                  skid_data <= sel_data;
                  skid_err  <= sel_err;
                  state     <= FULL;
                  in_ready  <= 1'b0;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only the output side can move.
               if (out_ready) begin
                  out_data <= skid_data;
                  out_err  <= skid_err;
                  state    <= BUSY;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state     <= EMPTY;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

`ifdef PIPE_MUX_SKID_STAT_EN
   // Counts output fires. The count saturates rather than wraps, so a long
   // run never reads back as a small number.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_cnt <= '0;
      end else if (flush) begin
         stat_cnt <= '0;
      end else if (out_fire && (stat_cnt != 16'hFFFF)) begin
         stat_cnt <= stat_cnt + 16'd1;
      end
   end
`endif

   // A stalled output must not change under the consumer.
   a_out_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready && !flush) |=>
         (out_valid && $stable(out_data) && $stable(out_err)));

   // out_fire is used only by the counter and is otherwise unused.
   logic unused_ok;
   assign unused_ok = out_fire;

endmodule

// File: tb/tb_pipe_mux_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_mux_skid
//
// Bench for pipe_mux_skid. Two instances are checked:
//   u_dut   WIDTH=32, NUM_IN=4
//   u_dut3  WIDTH=16, NUM_IN=3, where select index 3 is out of range
// The instances share clock, reset and handshake controls, but each has its
// own data and select inputs. Expected values come from table constants or
// from a queue-based model of the transfer stream.
// -----------------------------------------------------------------------------
module tb_pipe_mux_skid;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int W3 = 16;
   localparam int N3 = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N*W-1:0]  in_data;
   logic [1:0]      in_sel;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    out_data;
   logic            out_err;
   logic            out_valid;
   logic            out_ready;
   logic            flush;

   logic [N3*W3-1:0] in_data3;
   logic [1:0]       in_sel3;
   logic             in_ready3;
   logic [W3-1:0]    out_data3;
   logic             out_err3;
   logic             out_valid3;

`ifdef PIPE_MUX_SKID_STAT_EN
   logic [15:0] stat_cnt;
   logic [15:0] stat_cnt3;
`endif

   pipe_mux_skid #(.WIDTH(W), .NUM_IN(N)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .flush     (flush)
`ifdef PIPE_MUX_SKID_STAT_EN
      ,
      .stat_cnt  (stat_cnt)
`endif
   );

   pipe_mux_skid #(.WIDTH(W3), .NUM_IN(N3)) u_dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data3),
      .in_sel    (in_sel3),
      .in_valid  (in_valid),
      .in_ready  (in_ready3),
      .out_data  (out_data3),
      .out_err   (out_err3),
      .out_valid (out_valid3),
      .out_ready (out_ready),
      .flush     (flush)
`ifdef PIPE_MUX_SKID_STAT_EN
      ,
      .stat_cnt  (stat_cnt3)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Move to 1 time unit after the next rising edge. Inputs are driven and
   // outputs sampled there.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: the transfers currently held by each block, oldest
   // first. The block holds at most two, and it is ready while it holds fewer.
   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } item_t;

   item_t q_a[$];
   item_t q_b[$];

   function automatic item_t pick(input logic [127:0] d, input int sel, input int n, input int w);
      item_t it;
      int    idx;
      idx     = (sel < n) ? sel : n - 1;
      it.err  = (sel >= n);
      it.data = 32'((d >> (idx * w)) & ((128'd1 << w) - 128'd1));
      return it;
   endfunction

   typedef struct {
      logic [N*W-1:0]   d;
      logic [1:0]       s;
      logic [W-1:0]     ed;
      logic             ee;
      logic [N3*W3-1:0] d3;
      logic [1:0]       s3;
      logic [W3-1:0]    ed3;
      logic             ee3;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{{32'h44, 32'h33, 32'h22, 32'h11}, 2'd0, 32'h11, 1'b0,
                  {16'hCAFE, 16'hBEEF, 16'h1234}, 2'd3, 16'hCAFE, 1'b1};
      vecs[1] = '{{32'h44, 32'h33, 32'h22, 32'h11}, 2'd1, 32'h22, 1'b0,
                  {16'hCAFE, 16'hBEEF, 16'h1234}, 2'd0, 16'h1234, 1'b0};
      vecs[2] = '{{32'h44, 32'h33, 32'h22, 32'h11}, 2'd2, 32'h33, 1'b0,
                  {16'hCAFE, 16'hBEEF, 16'h1234}, 2'd1, 16'hBEEF, 1'b0};
      vecs[3] = '{{32'h44, 32'h33, 32'h22, 32'h11}, 2'd3, 32'h44, 1'b0,
                  {16'hCAFE, 16'hBEEF, 16'h1234}, 2'd2, 16'hCAFE, 1'b0};
      vecs[4] = '{{32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 32'h5A5A5A5A}, 2'd1, 32'hFFFFFFFF, 1'b0,
                  {16'h0001, 16'h8000, 16'hFFFF}, 2'd3, 16'h0001, 1'b1};
      vecs[5] = '{{32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 32'h5A5A5A5A}, 2'd3, 32'hDEADBEEF, 1'b0,
                  {16'h0001, 16'h8000, 16'hFFFF}, 2'd0, 16'hFFFF, 1'b0};

      in_valid  = 1'b0;
      out_ready = 1'b1;
      flush     = 1'b0;
      in_data   = '0;
      in_sel    = '0;
      in_data3  = '0;
      in_sel3   = '0;
      rst_n     = 1'b1;

      // ---- reset state -------------------------------------------------
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data,  0);
      check("rst_out_err",   out_err,   0);
      check("rst_in_ready",  in_ready,  1);
      check("rst3_out_valid", out_valid3, 0);
      check("rst3_in_ready",  in_ready3,  1);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // ---- table: streaming at one transfer per cycle --------------------
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = vecs[i].d;
         in_sel   = vecs[i].s;
         in_data3 = vecs[i].d3;
         in_sel3  = vecs[i].s3;
         step();
         check($sformatf("tbl%0d_valid", i), out_valid, 1);
         check($sformatf("tbl%0d_data", i),  out_data,  vecs[i].ed);
         check($sformatf("tbl%0d_err", i),   out_err,   vecs[i].ee);
         check($sformatf("tbl%0d_ready", i), in_ready,  1);
         check($sformatf("tbl%0d_data3", i), out_data3, vecs[i].ed3);
         check($sformatf("tbl%0d_err3", i),  out_err3,  vecs[i].ee3);
      end
      in_valid = 1'b0;
      step();
      check("tbl_drain_valid", out_valid, 0);

      // ---- back-pressure: A held, B in the skid slot, C refused ---------
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      in_data   = {96'h0, 32'hA0A0_0001};
      step();
      check("bp_a_valid", out_valid, 1);
      check("bp_a_data",  out_data,  32'hA0A0_0001);
      check("bp_a_ready", in_ready,  1);
      in_data = {96'h0, 32'hB0B0_0002};
      step();
      check("bp_b_data",  out_data, 32'hA0A0_0001);
      check("bp_b_ready", in_ready, 0);
      in_data = {96'h0, 32'hC0C0_0003};
      step();
      check("bp_c_valid", out_valid, 1);
      check("bp_c_data",  out_data,  32'hA0A0_0001);
      check("bp_c_ready", in_ready,  0);
      out_ready = 1'b1;
      step();
      check("bp_rel_b_data", out_data, 32'hB0B0_0002);
      check("bp_rel_ready",  in_ready, 1);
      step();
      check("bp_rel_c_data",  out_data,  32'hC0C0_0003);
      check("bp_rel_c_valid", out_valid, 1);
      in_valid = 1'b0;
      step();
      check("bp_drain_valid", out_valid, 0);

      // ---- flush while full, consumer ready in the same cycle ------------
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = {96'h0, 32'h1111_AAAA};
      step();
      in_data = {96'h0, 32'h2222_BBBB};
      step();
      check("fl_full_ready", in_ready, 0);
      in_valid  = 1'b0;
      flush     = 1'b1;
      out_ready = 1'b1;
      step();
      flush = 1'b0;
      check("fl_valid", out_valid, 0);
      check("fl_ready", in_ready,  1);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("fl_after%0d_valid", i), out_valid, 0);
      end

      // ---- async reset between edges ----------------------------------
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = {96'h0, 32'hD0D0_0004};
      step();
      in_data = {96'h0, 32'hE0E0_0005};
      step();
      check("ar_pre_valid", out_valid, 1);
      check("ar_pre_ready", in_ready,  0);
      #2 rst_n = 1'b0;
      #1;
      check("ar_valid", out_valid, 0);
      check("ar_ready", in_ready,  1);
      check("ar_data",  out_data,  0);
      in_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      check("ar_post_valid", out_valid, 0);

      // ---- randomized traffic against the queue model ------------------
      q_a.delete();
      q_b.delete();
      for (int c = 0; c < 800; c++) begin
         check("rnd_valid",  out_valid,  q_a.size() > 0);
         check("rnd_ready",  in_ready,   q_a.size() < 2);
         check("rnd_valid3", out_valid3, q_b.size() > 0);
         check("rnd_ready3", in_ready3,  q_b.size() < 2);
         if (q_a.size() > 0) begin
            check("rnd_data", out_data, q_a[0].data);
            check("rnd_err",  out_err,  q_a[0].err);
         end
         if (q_b.size() > 0) begin
            check("rnd_data3", out_data3, q_b[0].data);
            check("rnd_err3",  out_err3,  q_b[0].err);
         end

         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 31) == 0);
         in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
         in_sel    = 2'($urandom_range(0, 3));
         in_data3  = 48'({$urandom(), $urandom()});
         in_sel3   = 2'($urandom_range(0, 3));

         if (flush) begin
            q_a.delete();
            q_b.delete();
         end else begin
            logic acc;
            acc = in_valid && (q_a.size() < 2);
            if (out_ready && q_a.size() > 0) begin
               void'(q_a.pop_front());
               void'(q_b.pop_front());
            end
            if (acc) begin
               q_a.push_back(pick(128'(in_data), int'(in_sel), N, W));
               q_b.push_back(pick(128'(in_data3), int'(in_sel3), N3, W3));
            end
         end
         step();
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;

`ifdef PIPE_MUX_SKID_STAT_EN
      // ---- output-fire counter ----------------------------------------
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("st_clear", stat_cnt, 0);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) step();
      in_valid = 1'b0;
      step();
      check("st_five",  stat_cnt,  5);
      check("st_five3", stat_cnt3, 5);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("st_flushed", stat_cnt, 0);
      in_valid = 1'b1;
      for (int i = 0; i < 65535; i++) step();
      in_valid = 1'b0;
      step();
      check("st_max", stat_cnt, 16'hFFFF);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check("st_saturate", stat_cnt, 16'hFFFF);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
